// File: rtl/aes_decrypt_top.sv
// aes_decrypt_top: iterative AES-128 inverse cipher, one round per clock.
// The cipher key is first expanded forward to round key 10. The schedule is
// then walked backwards alongside the inverse rounds, so no round keys are stored.
module aes_decrypt_top #(
    parameter int NR          = 10,
    parameter bit RK_BACKWARD = 1'b1
) (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, DONE} fsmState_t;

    localparam logic [3:0] LAST_IDX   = 4'(NR - 1);
    localparam logic [3:0] FINAL_RCON = 4'(NR);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gfInv(input logic [7:0] x);
        logic [7:0] result;
        logic [7:0] power;
        result = 8'h01;
        power  = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) result = gfMul(result, power);
            power = gfMul(power, power);
        end
        return result;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gfInv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] x);
        logic [7:0] b;
        b = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
        return gfInv(b);
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] invMixCol(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gfMul(8'h0e, a0) ^ gfMul(8'h0b, a1) ^ gfMul(8'h0d, a2) ^ gfMul(8'h09, a3),
                gfMul(8'h09, a0) ^ gfMul(8'h0e, a1) ^ gfMul(8'h0b, a2) ^ gfMul(8'h0d, a3),
                gfMul(8'h0d, a0) ^ gfMul(8'h09, a1) ^ gfMul(8'h0e, a2) ^ gfMul(8'h0b, a3),
                gfMul(8'h0b, a0) ^ gfMul(8'h0d, a1) ^ gfMul(8'h09, a2) ^ gfMul(8'h0e, a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    fsmState_t    r_fsm;
    fsmState_t    w_nextFsm;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_cnt;

    logic         w_load;
    logic         w_kexpStep;
    logic         w_addkStep;
    logic         w_roundStep;
    logic         w_release;
    logic         w_lastRound;

    logic [127:0] w_addKey;
    logic [127:0] w_mixed;
    logic [127:0] w_roundOut;
    logic [3:0]   w_rconIdx;
    logic [31:0]  w_sboxIn;
    logic [31:0]  w_temp;
    logic [31:0]  w_fwd0, w_fwd1, w_fwd2, w_fwd3;
    logic [127:0] w_fwdKey;
    logic [127:0] w_invKey;
    logic [127:0] w_backKey;

    // State register
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) r_fsm <= IDLE;
        else            r_fsm <= w_nextFsm;
    end

    // Next-state logic: fixed-length walk KEXP -> ADDK -> ROUND -> DONE
    always_comb begin
        w_nextFsm = r_fsm;
        case (r_fsm)
            IDLE:    if (AES_en) w_nextFsm = KEXP;
            KEXP:    if (r_cnt == LAST_IDX) w_nextFsm = ADDK;
            ADDK:    w_nextFsm = ROUND;
            ROUND:   if (r_cnt == 4'd0) w_nextFsm = DONE;
            DONE:    if (!AES_en) w_nextFsm = IDLE;
            default: w_nextFsm = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        w_load      = 1'b0;
        w_kexpStep  = 1'b0;
        w_addkStep  = 1'b0;
        w_roundStep = 1'b0;
        w_release   = 1'b0;
        case (r_fsm)
            IDLE:    w_load      = AES_en;
            KEXP:    w_kexpStep  = 1'b1;
            ADDK:    w_addkStep  = 1'b1;
            ROUND:   w_roundStep = 1'b1;
            DONE:    w_release   = !AES_en;
            default: ;
        endcase
    end

    assign w_lastRound = w_roundStep && (r_cnt == 4'd0);

    // Rcon index: forward steps count up from 1, the inverse step uses the round being undone
    always_comb begin
        w_rconIdx = r_cnt;
        if (r_fsm == KEXP)      w_rconIdx = r_cnt + 4'd1;
        else if (r_fsm == ADDK) w_rconIdx = FINAL_RCON;
    end

    // One shared SubWord serves both directions; backwards it needs the recovered last word
    assign w_sboxIn = (r_fsm == KEXP) ? r_key[31:0] : (r_key[31:0] ^ r_key[63:32]);
    assign w_temp   = subWord({w_sboxIn[23:0], w_sboxIn[31:24]}) ^ {rcon(w_rconIdx), 24'h000000};

    assign w_fwd0   = r_key[127:96] ^ w_temp;
    assign w_fwd1   = r_key[95:64]  ^ w_fwd0;
    assign w_fwd2   = r_key[63:32]  ^ w_fwd1;
    assign w_fwd3   = r_key[31:0]   ^ w_fwd2;
    assign w_fwdKey = {w_fwd0, w_fwd1, w_fwd2, w_fwd3};

    assign w_invKey = {r_key[127:96] ^ w_temp,
                       r_key[95:64]  ^ r_key[127:96],
                       r_key[63:32]  ^ r_key[95:64],
                       r_key[31:0]   ^ r_key[63:32]};

    // The value 0 is reserved for a stored-key variant; the key is simply held then
    assign w_backKey = RK_BACKWARD ? w_invKey : r_key;

    // Round datapath: InvShiftRows folded into byte selection, then InvSubBytes, AddRoundKey, InvMixColumns
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = r + 4 * c;
            localparam int SRC = r + 4 * ((c + 4 - r) % 4);
            assign w_addKey[8*(15-DST) +: 8] = invSbox(r_state[8*(15-SRC) +: 8]) ^ r_key[8*(15-DST) +: 8];
        end
        assign w_mixed[32*(3-c) +: 32] = invMixCol(w_addKey[32*(3-c) +: 32]);
    end

    assign w_roundOut = (r_cnt == 4'd0) ? w_addKey : w_mixed;

    // Datapath registers: capture, forward expansion, initial whitening, inverse rounds
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_state <= 128'h0;
            r_key   <= 128'h0;
            r_cnt   <= 4'd0;
        end else if (w_load) begin
            r_state <= AES_data_in;
            r_key   <= AES_key_in;
            r_cnt   <= 4'd0;
        end else if (w_kexpStep) begin
            r_key   <= w_fwdKey;
            r_cnt   <= r_cnt + 4'd1;
        end else if (w_addkStep) begin
            r_state <= r_state ^ r_key;
            r_key   <= w_backKey;
            r_cnt   <= LAST_IDX;
        end else if (w_roundStep) begin
            r_state <= w_roundOut;
            r_key   <= w_backKey;
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
    end

    // Registered outputs: plaintext held until the next result, valid cleared when en drops in DONE
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            AES_data_out       <= 128'h0;
            AES_data_out_valid <= 1'b0;
        end else if (w_lastRound) begin
            AES_data_out       <= w_roundOut;
            AES_data_out_valid <= 1'b1;
        end else if (w_release) begin
            AES_data_out_valid <= 1'b0;
        end
    end

endmodule
